// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32x32 register file with write-through read ports, committed-write counter
// Ports:
//   clk, reset (async, active-low)
//   alu_jump, mem_data, imm : candidate write-back values from MEM/WB
//   rd, esc_reg             : destination index and write enable from MEM/WB
//   lw, lui                 : write-back select (lw has priority over lui)
//   rs1, rs2 -> rdata1/2    : combinational read ports with same-cycle bypass
//   wb_data                 : selected write-back value
//   wr_count                : number of committed register writes (wraps)
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_jump,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    input  logic            esc_reg,
    input  logic            lw,
    input  logic            lui,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     wr_count
);
    logic [XLEN-1:0] regs [NREG];
    logic            we;

    assign wb_data = lw ? mem_data : lui ? imm : alu_jump;
    assign we      = esc_reg && (rd != 5'd0);

    // Entry 0 is never written; reads of index 0 are forced to zero below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            wr_count <= '0;
        end else if (we) begin
            regs[rd] <= wb_data;
            wr_count <= wr_count + 32'd1;
        end
    end

    // Reads are zeroed while reset is held so the bypass path cannot leak a value.
    assign rdata1 = (!reset || rs1 == 5'd0) ? '0 : (we && rs1 == rd) ? wb_data : regs[rs1];
    assign rdata2 = (!reset || rs2 == 5'd0) ? '0 : (we && rs2 == rd) ? wb_data : regs[rs2];
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors, async reset corners and randomized reference-model check of wb_regfile
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] alu_jump = '0, mem_data = '0, imm = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic        esc_reg = 1'b0, lw = 1'b0, lui = 1'b0;
    logic [31:0] rdata1, rdata2, wb_data, wr_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        lw, lui, esc;
        logic [4:0]  rd;
        logic [31:0] alu, mem, imm;
        logic [4:0]  rs1, rs2;
        logic [31:0] ewb, er1, er2, ecnt;
    } vec_t;

    vec_t tv [9];

    logic [31:0] m [32];
    logic [31:0] mcnt;

    wb_regfile dut (
        .clk(clk), .reset(reset), .alu_jump(alu_jump), .mem_data(mem_data), .imm(imm),
        .rd(rd), .esc_reg(esc_reg), .lw(lw), .lui(lui), .rs1(rs1), .rs2(rs2),
        .rdata1(rdata1), .rdata2(rdata2), .wb_data(wb_data), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_wb(input logic l, input logic u, input logic [31:0] a,
                                           input logic [31:0] md, input logic [31:0] im);
        if (l) return md;
        if (u) return im;
        return a;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rs);
        logic [31:0] w;
        w = sel_wb(lw, lui, alu_jump, mem_data, imm);
        if (rs == 5'd0) return 32'd0;
        if (esc_reg && rd != 5'd0 && rs == rd) return w;
        return m[rs];
    endfunction

    initial begin
        tv[0] = '{1'b1, 1'b1, 1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd0, 32'h22, 32'h22, 32'h0, 32'd1};
        tv[1] = '{1'b0, 1'b1, 1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5, 32'h33, 32'h33, 32'h33, 32'd2};
        tv[2] = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd3, 32'h11, 32'h11, 32'h0, 32'd3};
        tv[3] = '{1'b0, 1'b0, 1'b0, 5'd5, 32'h44, 32'h22, 32'h33, 5'd5, 5'd5, 32'h44, 32'h11, 32'h11, 32'd3};
        tv[4] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'd3};
        tv[5] = '{1'b0, 1'b0, 1'b1, 5'd7, 32'hA, 32'h0, 32'h0, 5'd7, 5'd5, 32'hA, 32'hA, 32'h11, 32'd4};
        tv[6] = '{1'b0, 1'b0, 1'b0, 5'd7, 32'hB, 32'h0, 32'h0, 5'd7, 5'd7, 32'hB, 32'hA, 32'hA, 32'd4};
        tv[7] = '{1'b0, 1'b0, 1'b1, 5'd7, 32'hB, 32'h0, 32'h0, 5'd7, 5'd7, 32'hB, 32'hB, 32'hB, 32'd5};
        tv[8] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0, 32'h0, 32'hB, 32'h0, 32'd5};

        // Reset held: random inputs, every read index returns 0, wb_data still follows inputs.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            alu_jump = $urandom; mem_data = $urandom; imm = $urandom;
            lw = 1'($urandom); lui = 1'($urandom); esc_reg = 1'b1;
            rd = 5'(i); rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            chk("reset_rdata1", rdata1, 32'd0);
            chk("reset_rdata2", rdata2, 32'd0);
            chk("reset_wb", wb_data, sel_wb(lw, lui, alu_jump, mem_data, imm));
            @(posedge clk); #1;
            chk("reset_cnt", wr_count, 32'd0);
        end

        // Release with the MEM/WB reset pattern (esc_reg=1, rd=0): no write.
        @(negedge clk);
        reset = 1'b1; esc_reg = 1'b1; rd = 5'd0; rs1 = 5'd5; rs2 = 5'd31;
        @(posedge clk); #1;
        chk("release_cnt", wr_count, 32'd0);
        chk("release_r1", rdata1, 32'd0);
        chk("release_r2", rdata2, 32'd0);

        // Directed vectors: select priority, x0 protection, bypass.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            lw = tv[i].lw; lui = tv[i].lui; esc_reg = tv[i].esc; rd = tv[i].rd;
            alu_jump = tv[i].alu; mem_data = tv[i].mem; imm = tv[i].imm;
            rs1 = tv[i].rs1; rs2 = tv[i].rs2;
            #1;
            chk($sformatf("vec%0d_wb", i), wb_data, tv[i].ewb);
            chk($sformatf("vec%0d_r1", i), rdata1, tv[i].er1);
            chk($sformatf("vec%0d_r2", i), rdata2, tv[i].er2);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_cnt", i), wr_count, tv[i].ecnt);
        end
        @(negedge clk);
        esc_reg = 1'b0; rs1 = 5'd5; rs2 = 5'd7;
        #1;
        chk("post_x5", rdata1, 32'h11);
        chk("post_x7", rdata2, 32'hB);

        // Asynchronous reset between edges during a write.
        esc_reg = 1'b1; lw = 1'b0; lui = 1'b0; rd = 5'd9; alu_jump = 32'h55; rs1 = 5'd7; rs2 = 5'd9;
        #2;
        reset = 1'b0;
        #1;
        chk("async_cnt", wr_count, 32'd0);
        chk("async_r1", rdata1, 32'd0);
        chk("async_r2", rdata2, 32'd0);
        chk("async_wb", wb_data, 32'h55);
        @(posedge clk); #1;
        chk("async_hold_cnt", wr_count, 32'd0);
        @(negedge clk);
        alu_jump = 32'h66;
        reset = 1'b1;
        #1;
        chk("rel_bypass", rdata2, 32'h66);
        chk("rel_x7_cleared", rdata1, 32'd0);
        @(posedge clk); #1;
        chk("rel_first_cnt", wr_count, 32'd1);

        // Randomized run against the reference model.
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m[9] = 32'h66;
        mcnt = 32'd1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            alu_jump = $urandom; mem_data = $urandom; imm = $urandom;
            lw = ($urandom_range(3) == 0); lui = ($urandom_range(2) == 0);
            esc_reg = ($urandom_range(3) != 0);
            rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            rs1 = ($urandom_range(3) == 0) ? rd : 5'($urandom);
            rs2 = ($urandom_range(3) == 0) ? rd : 5'($urandom);
            #1;
            chk("rnd_wb", wb_data, sel_wb(lw, lui, alu_jump, mem_data, imm));
            chk("rnd_r1", rdata1, model_read(rs1));
            chk("rnd_r2", rdata2, model_read(rs2));
            if (esc_reg && rd != 5'd0) begin
                m[rd] = sel_wb(lw, lui, alu_jump, mem_data, imm);
                mcnt = mcnt + 32'd1;
            end
            @(posedge clk); #1;
            chk("rnd_cnt", wr_count, mcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the pipelined RISC-V core. It consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32 x 32-bit register file. It serves two combinational read ports to the decode stage, with same-cycle write-through bypass. It also keeps a committed-write counter used by the merge-sort test programs.

## Interface
Parameters:
- XLEN, 32, data width of registers and write-back path.
- NREG, 32, number of architectural registers (index width 5).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- alu_jump  input  XLEN  ALU result / jump return address from MEM/WB.
- mem_data  input  XLEN  load data from MEM/WB.
- imm  input  XLEN  immediate from MEM/WB (LUI path).
- rd  input  5  destination register index from MEM/WB.
- esc_reg  input  1  register-write enable from MEM/WB.
- lw  input  1  selects mem_data as write-back value.
- lui  input  1  selects imm as write-back value.
- rs1, rs2  input  5 each  decode-stage read indices.
- rdata1, rdata2  output  XLEN each  read data, combinational.
- wb_data  output  XLEN  selected write-back value, combinational.
- wr_count  output  32  number of committed register writes.

## Operation
- Write-back select, combinational, priority lw > lui > default:
  - lw=1 -> wb_data = mem_data.
  - lw=0, lui=1 -> wb_data = imm.
  - otherwise -> wb_data = alu_jump.
- Commit condition: we = esc_reg & (rd != 0).
- When we=1 at a rising edge, regs[rd] <= wb_data and wr_count <= wr_count + 1.
- wr_count wraps modulo 2^32: 0xFFFFFFFF + 1 = 0.
- x0 is hardwired to zero:
  - it is never stored;
  - reading index 0 returns 0 on either port, including when rd=0 with esc_reg=1.
- Read ports, combinational and independent:
  - rs=0 -> 0.
  - else if we=1 and rs==rd -> wb_data (write-first bypass).
  - else regs[rs].
- Both ports may read the same index; both may hit the bypass together.
- The MEM/WB register emits esc_reg=1, rd=0 coming out of reset. This is a harmless no-op: no write occurs and wr_count does not increment.

## Timing
- Reset (reset=0), asynchronous and immediate, independent of clk:
  - regs[1..31] = 0.
  - wr_count = 0.
  - rdata1/rdata2 therefore read 0.
  - wb_data continues to follow its inputs.
- Reset asserted mid-write: the write is lost; the register stays 0 while reset is low.
- Write latency: data is visible via the array one cycle after the commit edge, and visible the same cycle via the bypass.
- No stall, handshake or backpressure: every cycle with we=1 commits exactly one write.
- Reset release: the first edge with reset=1 and we=1 commits normally.

## Test plan
- Reset: hold reset=0, randomize inputs -> all rdata=0 for rs 0..31, wr_count=0; release -> still 0 until a write.
- Select priority: rd=5, esc_reg=1, alu_jump=0x11, mem_data=0x22, imm=0x33:
  - lw=1, lui=1 -> x5=0x22.
  - lw=0, lui=1 -> x5=0x33.
  - lw=0, lui=0 -> x5=0x11.
  - wr_count=3.
- x0 protection: esc_reg=1, rd=0, alu_jump=0xDEADBEEF, rs1=rs2=0 -> rdata=0 before and after the edge, wr_count unchanged.
- Bypass: x7 holds 0xA; same cycle rd=7, esc_reg=1, alu_jump=0xB, rs1=7, rs2=7 -> rdata1=rdata2=0xB before the edge, 0xB after. With esc_reg=0 -> 0xA.
- Counter wrap: force 2^32-1 writes (or preload via back-to-back writes in a shortened bench) -> the next write gives wr_count=0.
- Async reset mid-stream: writes to x1..x31 in progress, drop reset between edges -> all outputs 0 immediately, not at the next edge.
